// File: rtl/system_nios_led_ctrl_if.sv
// Avalon-MM slave bus bundle for the LED/output-port controller.
//
// Bus semantics: there is no valid/ready pair. The bus has zero wait states.
// A write is accepted on the rising clk edge when chipselect is high and
// write_n is low. Only one write can happen per cycle.
// readdata is combinational from address and is never stalled. It is not
// qualified by chipselect, and reading has no side effects.
interface system_nios_led_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/system_nios_led_ctrl.sv
// LED / output-port controller.
// Provides WIDTH registered output lines with these features:
// - atomic set and clear of output bits,
// - per-bit blink driven by a programmable prescaler,
// - global PWM dimming.
// With default parameters and no blink/duty writes, it behaves as a plain PIO.
module system_nios_led_ctrl #(
  parameter int          WIDTH      = 8,
  parameter logic [31:0] INIT_VALUE = 32'h0,
  parameter int          PRESC_W    = 24,
  parameter int          DUTY_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  system_nios_led_ctrl_if.slave bus,
  output logic [WIDTH-1:0]     out_port
);

  localparam logic [WIDTH-1:0]  INIT_V   = INIT_VALUE[WIDTH-1:0];
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_SET      = 3'd1;
  localparam logic [2:0] A_CLEAR    = 3'd2;
  localparam logic [2:0] A_BLINK    = 3'd3;
  localparam logic [2:0] A_PRESCALE = 3'd4;
  localparam logic [2:0] A_DUTY     = 3'd5;
  localparam logic [2:0] A_OUTSTAT  = 3'd6;

  logic               wr_en;
  logic [WIDTH-1:0]   wd_w;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   data_d;
  logic [WIDTH-1:0]   blink_q;
  logic [PRESC_W-1:0] presc_q;
  logic [DUTY_W-1:0]  duty_q;
  logic [PRESC_W-1:0] pcnt_q;
  logic               phase_q;
  logic [DUTY_W-1:0]  wcnt_q;
  logic               pwm_on;
  logic [WIDTH-1:0]   out_d;
  logic [31:0]        rdata;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign wd_w  = bus.writedata[WIDTH-1:0];

  // Compute the next DATA value from a write to DATA, SET or CLEAR.
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (bus.address)
        A_DATA:  data_d = wd_w;
        A_SET:   data_d = data_q | wd_w;
        A_CLEAR: data_d = data_q & ~wd_w;
        default: data_d = data_q;
      endcase
    end
  end

  // Hold the programmable registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= INIT_V;
      blink_q <= '0;
      presc_q <= '0;
      duty_q  <= DUTY_MAX;
    end else begin
      data_q <= data_d;
      if (wr_en && bus.address == A_BLINK)    blink_q <= wd_w;
      if (wr_en && bus.address == A_PRESCALE) presc_q <= bus.writedata[PRESC_W-1:0];
      if (wr_en && bus.address == A_DUTY)     duty_q  <= bus.writedata[DUTY_W-1:0];
    end
  end

  // Run the blink prescaler.
  // A PRESCALE write restarts the half-period with phase high, and it
  // overrides a wrap that would otherwise happen on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q  <= '0;
      phase_q <= 1'b1;
    end else if (wr_en && bus.address == A_PRESCALE) begin
      pcnt_q  <= '0;
      phase_q <= 1'b1;
    end else if (pcnt_q == presc_q) begin
      pcnt_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

  // Run the free-running PWM counter.
  // A DUTY write does not disturb this counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wcnt_q <= '0;
    else          wcnt_q <= wcnt_q + 1'b1;
  end

  // Decide PWM on-time.
  // When DUTY is all-ones the output is forced fully on, so there is no
  // one-cycle dip when the counter wraps.
  always_comb begin
    pwm_on = (duty_q == DUTY_MAX) | (wcnt_q < duty_q);
    out_d  = data_q & (~blink_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};
  end

  // Register the output lines.
  // out_port follows a register write by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= INIT_V;
    else          out_port <= out_d;
  end

  // Build readdata: zero-extended, combinational from address.
  always_comb begin
    rdata = '0;
    case (bus.address)
      A_DATA, A_SET, A_CLEAR: rdata[WIDTH-1:0]   = data_q;
      A_BLINK:                rdata[WIDTH-1:0]   = blink_q;
      A_PRESCALE:             rdata[PRESC_W-1:0] = presc_q;
      A_DUTY:                 rdata[DUTY_W-1:0]  = duty_q;
      A_OUTSTAT:              rdata[WIDTH-1:0]   = out_port;
      default:                rdata              = '0;
    endcase
  end

  assign bus.readdata = rdata;

endmodule

// File: tb/tb_system_nios_led_ctrl.sv
// Directed testbench for system_nios_led_ctrl with default parameters:
// WIDTH=8, INIT_VALUE=0, PRESC_W=24, DUTY_W=8.
module tb_system_nios_led_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;
  int         checks;
  int         errors;

  system_nios_led_ctrl_if bus_if ();

  system_nios_led_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    bus_if.address = a;
    #1;
    v = bus_if.readdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v;
    reset_n           = 1'b0;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL reset_out_port: got %h expected 00", out_port);
    end
    bus_read(3'd0, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", v);
    end
    bus_read(3'd5, v);
    checks++;
    if (v !== 32'hFF) begin
      errors++;
      $display("FAIL reset_duty: got %h expected ff", v);
    end
    bus_read(3'd7, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsvd: got %h expected 0", v);
    end
    bus_read(3'd3, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL reset_blink: got %h expected 0", v);
    end
    bus_read(3'd4, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL reset_prescale: got %h expected 0", v);
    end
  endtask

  task automatic test_set_clear();
    logic [31:0] v;
    logic [31:0] wdat [3];
    logic [2:0]  wadr [3];
    logic [7:0]  exp_v [3];
    logic [7:0]  prev;
    wadr[0] = 3'd0; wdat[0] = 32'hFFFF_FFA5; exp_v[0] = 8'hA5;
    wadr[1] = 3'd1; wdat[1] = 32'h0000_000F; exp_v[1] = 8'hAF;
    wadr[2] = 3'd2; wdat[2] = 32'h0000_0081; exp_v[2] = 8'h2E;
    prev = 8'h00;
    for (int i = 0; i < 3; i++) begin
      bus_write(wadr[i], wdat[i]);
      bus_read(wadr[i], v);
      checks++;
      if (v !== {24'h0, exp_v[i]}) begin
        errors++;
        $display("FAIL data_read_%0d: got %h expected %h", i, v, exp_v[i]);
      end
      checks++;
      if (out_port !== prev) begin
        errors++;
        $display("FAIL out_latency_%0d: got %h expected %h", i, out_port, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_port !== exp_v[i]) begin
        errors++;
        $display("FAIL out_follow_%0d: got %h expected %h", i, out_port, exp_v[i]);
      end
      prev = exp_v[i];
    end
    bus_read(3'd6, v);
    checks++;
    if (v !== 32'h2E) begin
      errors++;
      $display("FAIL outstat: got %h expected 2e", v);
    end
    bus_write(3'd6, 32'hFF);
    bus_write(3'd7, 32'hFF);
    bus_read(3'd7, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL rsvd_write: got %h expected 0", v);
    end
    bus_read(3'd0, v);
    checks++;
    if (v !== 32'h2E) begin
      errors++;
      $display("FAIL ro_write_data: got %h expected 2e", v);
    end
  endtask

  task automatic test_blink();
    logic [31:0] v;
    logic [7:0]  exp_o;
    bus_write(3'd0, 32'hFF);
    bus_write(3'd3, 32'h01);
    bus_write(3'd4, 32'h3);
    bus_read(3'd4, v);
    checks++;
    if (v !== 32'h3) begin
      errors++;
      $display("FAIL prescale_read: got %h expected 3", v);
    end
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      exp_o = ((((i - 1) / 4) % 2) == 0) ? 8'hFF : 8'hFE;
      checks++;
      if (out_port !== exp_o) begin
        errors++;
        $display("FAIL blink_cyc%0d: got %h expected %h", i, out_port, exp_o);
      end
    end
  endtask

  task automatic test_prescale_wrap();
    logic [31:0] v;
    logic [7:0]  exp_o;
    bus_write(3'd4, 32'h3);
    repeat (3) @(posedge clk);
    // This write lands on the edge where pcnt == PRESCALE.
    bus_write(3'd4, 32'h3);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      exp_o = (i <= 4) ? 8'hFF : 8'hFE;
      checks++;
      if (out_port !== exp_o) begin
        errors++;
        $display("FAIL wrap_cyc%0d: got %h expected %h", i, out_port, exp_o);
      end
      if (i == 1 || i == 5) begin
        bus_read(3'd6, v);
        checks++;
        if (v !== {24'h0, exp_o}) begin
          errors++;
          $display("FAIL wrap_outstat%0d: got %h expected %h", i, v, exp_o);
        end
      end
    end
  endtask

  task automatic test_pwm();
    logic [31:0] duty_tab [3];
    int          exp_cnt  [3];
    int          cnt;
    int          bad;
    duty_tab[0] = 32'd64;  exp_cnt[0] = 64;
    duty_tab[1] = 32'd0;   exp_cnt[1] = 0;
    duty_tab[2] = 32'd255; exp_cnt[2] = 256;
    bus_write(3'd3, 32'h00);
    bus_write(3'd0, 32'h01);
    for (int k = 0; k < 3; k++) begin
      bus_write(3'd5, duty_tab[k]);
      repeat (4) @(posedge clk);
      cnt = 0;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        @(posedge clk);
        #1;
        if (out_port === 8'h01) cnt++;
        else if (out_port !== 8'h00) bad++;
      end
      checks++;
      if (cnt !== exp_cnt[k]) begin
        errors++;
        $display("FAIL pwm_count_duty%0d: got %0d expected %0d", duty_tab[k], cnt, exp_cnt[k]);
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL pwm_other_bits_duty%0d: got %0d expected 0", duty_tab[k], bad);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [31:0] exp_r [5];
    logic [2:0]  adr   [5];
    adr[0] = 3'd0; exp_r[0] = 32'h00;
    adr[1] = 3'd3; exp_r[1] = 32'h00;
    adr[2] = 3'd4; exp_r[2] = 32'h00;
    adr[3] = 3'd5; exp_r[3] = 32'hFF;
    adr[4] = 3'd6; exp_r[4] = 32'h00;
    bus_write(3'd0, 32'hFF);
    bus_write(3'd3, 32'h0F);
    bus_write(3'd4, 32'h2);
    bus_write(3'd5, 32'd10);
    repeat (7) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL midreset_out: got %h expected 00", out_port);
    end
    for (int i = 0; i < 5; i++) begin
      bus_read(adr[i], v);
      checks++;
      if (v !== exp_r[i]) begin
        errors++;
        $display("FAIL midreset_reg%0d: got %h expected %h", adr[i], v, exp_r[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL midreset_hold: got %h expected 00", out_port);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_write(3'd0, 32'h01);
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_latency: got %h expected 00", out_port);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_port !== 8'h01) begin
      errors++;
      $display("FAIL post_reset_out: got %h expected 01", out_port);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_set_clear();
    test_blink();
    test_prescale_wrap();
    test_pwm();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
